// File: rtl/sw_job_scheduler.sv
// sw_job_scheduler
// Shares one Smith-Waterman (`sw`) engine among NUM_REQ requesters.
// The block does the following:
//   - picks a requester round-robin;
//   - streams that requester's sequence pair into the engine as one
//     contiguous INPUT_LENGTH-symbol burst;
//   - waits for the engine's finish, or for TIMEOUT cycles;
//   - returns the score on a valid/ready result port;
//   - pulses a local engine reset before the next job, because the engine
//     latches in its END state.
//
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-high reset
//   req               per-requester level request, held until granted
//   grant             one-hot, high through the whole LOAD of the job
//   rd_en             symbol strobe to the granted lane
//   s_bus, t_bus      packed lane symbols, lane i = bits [2i+1:2i]
//   eng_rst           reset to the engine (high in CLEAR)
//   eng_valid         engine valid strobe (registered)
//   eng_s, eng_t      engine data_s / data_t (registered)
//   eng_finish        engine finish
//   eng_max           engine score
//   res_valid         result available; res_ready accepts it
//   res_id            requester index of the result
//   res_max           score (0 on timeout)
//   res_timeout       job aborted by timeout
//   busy              high in every state except IDLE
module sw_job_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int INPUT_LENGTH = 256,
  parameter int TIMEOUT      = 1024,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 rd_en,
  input  logic [2*NUM_REQ-1:0] s_bus,
  input  logic [2*NUM_REQ-1:0] t_bus,
  output logic                 eng_rst,
  output logic                 eng_valid,
  output logic [1:0]           eng_s,
  output logic [1:0]           eng_t,
  input  logic                 eng_finish,
  input  logic [11:0]          eng_max,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [1:0]           res_id,
  output logic [11:0]          res_max,
  output logic                 res_timeout,
  output logic                 busy
);

  localparam int SYM_W = $clog2(INPUT_LENGTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    LOAD,
    WAIT,
    REPORT
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [SYM_W-1:0] sym_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [CLR_W-1:0] clr_cnt;
  logic [1:0]       ptr;
  logic [1:0]       cur_id;
  logic [1:0]       win_id;
  logic [1:0]       idx;
  logic             win_found;
  logic [1:0]       load_id;
  logic             sym_last;
  logic             to_last;
  logic             clr_last;

  assign sym_last = (sym_cnt == SYM_W'(INPUT_LENGTH - 1));
  assign to_last  = (to_cnt == TO_W'(TIMEOUT - 1));
  assign clr_last = (clr_cnt == CLR_W'(CLEAR_CYCLES - 1));

  // Round-robin search: walk downward from ptr+NUM_REQ-1 to ptr so that the
  // last hit, which is the one kept, is the requester closest to ptr.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Next-state logic. The lane that will own LOAD is the fresh winner when
  // leaving IDLE, otherwise the latched cur_id.
  always_comb begin
    next_state = state;
    load_id    = cur_id;
    case (state)
      CLEAR:  if (clr_last) next_state = IDLE;
      IDLE: begin
        load_id = win_id;
        if (win_found) next_state = LOAD;
      end
      LOAD:   if (sym_last) next_state = WAIT;
      WAIT:   if (eng_finish || to_last) next_state = REPORT;
      REPORT: if (res_valid && res_ready) next_state = CLEAR;
      default: next_state = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= next_state;
  end

  // Counters, arbitration pointer and all registered outputs. Control outputs
  // are decoded from next_state so that they line up with the state they
  // describe while still coming straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_cnt     <= '0;
      to_cnt      <= '0;
      clr_cnt     <= '0;
      ptr         <= '0;
      cur_id      <= '0;
      grant       <= '0;
      rd_en       <= 1'b0;
      eng_rst     <= 1'b1;
      busy        <= 1'b1;
      eng_valid   <= 1'b0;
      eng_s       <= '0;
      eng_t       <= '0;
      res_valid   <= 1'b0;
      res_id      <= '0;
      res_max     <= '0;
      res_timeout <= 1'b0;
    end else begin
      sym_cnt <= (state == LOAD && next_state == LOAD) ? sym_cnt + SYM_W'(1) : '0;
      to_cnt  <= (state == WAIT && next_state == WAIT) ? to_cnt + TO_W'(1) : '0;
      clr_cnt <= (state == CLEAR && next_state == CLEAR) ? clr_cnt + CLR_W'(1) : '0;

      if (state == IDLE && win_found) begin
        cur_id <= win_id;
        ptr    <= win_id + 2'd1;
      end

      grant   <= (next_state == LOAD) ? (NUM_REQ'(1) << load_id) : '0;
      rd_en   <= (next_state == LOAD);
      eng_rst <= (next_state == CLEAR);
      busy    <= (next_state != IDLE);

      // The engine sees the symbol one cycle after rd_en; eng_valid drops
      // exactly one cycle after the last LOAD cycle, marking end-of-input.
      eng_valid <= (state == LOAD);
      eng_s     <= (state == LOAD) ? s_bus[{cur_id, 1'b0} +: 2] : 2'b00;
      eng_t     <= (state == LOAD) ? t_bus[{cur_id, 1'b0} +: 2] : 2'b00;

      // Finish takes priority over a simultaneous timeout.
      if (state == WAIT && next_state == REPORT) begin
        res_valid   <= 1'b1;
        res_id      <= cur_id;
        res_max     <= eng_finish ? eng_max : 12'd0;
        res_timeout <= ~eng_finish;
      end else if (state == REPORT && next_state == CLEAR) begin
        res_valid   <= 1'b0;
        res_id      <= '0;
        res_max     <= '0;
        res_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sw_job_scheduler.sv
// tb_sw_job_scheduler
// Self-checking bench for sw_job_scheduler. A small model engine answers
// each job. A round-robin reference model predicts the winners. Each feature
// task drives a scenario and compares its observations inline.
module tb_sw_job_scheduler;

  localparam int INPUT_LENGTH = 256;
  localparam int TIMEOUT      = 1024;
  localparam int CLEAR_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic        rd_en;
  logic [7:0]  s_bus;
  logic [7:0]  t_bus;
  logic        eng_rst;
  logic        eng_valid;
  logic [1:0]  eng_s;
  logic [1:0]  eng_t;
  logic        eng_finish;
  logic [11:0] eng_max;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [11:0] res_max;
  logic        res_timeout;
  logic        busy;

  always #5 clk = ~clk;

  sw_job_scheduler #(
    .NUM_REQ(4), .INPUT_LENGTH(INPUT_LENGTH), .TIMEOUT(TIMEOUT), .CLEAR_CYCLES(CLEAR_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant), .rd_en(rd_en),
    .s_bus(s_bus), .t_bus(t_bus), .eng_rst(eng_rst), .eng_valid(eng_valid),
    .eng_s(eng_s), .eng_t(eng_t), .eng_finish(eng_finish), .eng_max(eng_max),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_max(res_max), .res_timeout(res_timeout), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference round-robin pointer and the winner it predicts for a job
  int         exp_ptr;
  logic [1:0] exp_id;

  // Observations gathered by run_job
  int         job_done, g_start, g_len, v_first, v_last, v_len, w_start;
  int         r_start, a_cyc, rst_len, data_err, rd_err, hold_err, grant_err;
  int         extra_res, idle_seen;
  logic [3:0] g_val;
  logic [1:0] r_id;
  logic [11:0] r_max;
  logic       r_to;

  function automatic logic [1:0] rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return 2'((p + k) % 4);
    return 2'd0;
  endfunction

  // Applies reset for a few cycles and waits for IDLE; resets the model pointer.
  task automatic do_reset();
    int n;
    reset = 1'b1; req = '0; res_ready = 1'b0; eng_finish = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_ptr = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 20);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_to_idle busy=%b expected=0", busy);
    end
  endtask

  // Drives one job and records what the DUT does. The call starts at a
  // negedge in IDLE and returns at the negedge of the first IDLE cycle after
  // the result was accepted.
  //   fin_delay   cycles after WAIT entry to raise finish (-1 = never)
  //   spur_at     LOAD symbol index with a spurious finish (-1 = none)
  //   ready_delay cycles of res_ready=0 after res_valid rises
  task automatic run_job(input logic [3:0] rq, input bit hold, input int fin_delay,
                         input logic [11:0] mx, input int spur_at, input int ready_delay);
    logic [3:0] sq[$];
    logic [3:0] sym;
    int cyc;
    int li;
    exp_id  = rr_pick(rq, exp_ptr);
    exp_ptr = (int'(exp_id) + 1) % 4;
    li = int'(exp_id);
    job_done = 0; g_start = -1; g_len = 0; v_first = -1; v_last = -1; v_len = 0;
    w_start = -1; r_start = -1; a_cyc = -1; rst_len = 0; data_err = 0; rd_err = 0;
    hold_err = 0; grant_err = 0; extra_res = 0; idle_seen = 0; g_val = '0;
    r_id = '0; r_max = '0; r_to = 1'b0;
    req = rq; res_ready = 1'b0; eng_finish = 1'b0;
    s_bus = 8'($urandom); t_bus = 8'($urandom);
    cyc = 0;
    while (job_done == 0 && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (eng_valid) begin
        if (v_len == 0) v_first = cyc;
        v_last = cyc; v_len++;
        if (sq.size() == 0) data_err++;
        else begin
          sym = sq.pop_front();
          if ({eng_s, eng_t} !== sym) data_err++;
        end
      end
      if (rd_en !== (grant != 4'b0000)) rd_err++;
      if (grant != 4'b0000) begin
        if (g_len == 0) begin g_start = cyc; g_val = grant; end
        else if (grant !== g_val) rd_err++;
        g_len++;
        if (!hold) req = req & ~grant;
      end else if (g_len > 0 && w_start < 0) begin
        w_start = cyc;
      end
      if (a_cyc >= 0) begin
        if (res_valid) extra_res++;
        if (eng_rst) rst_len++;
        if (cyc == a_cyc + CLEAR_CYCLES + 1) begin
          idle_seen = (busy == 1'b0) ? 1 : 0;
          job_done = 1;
        end
      end else if (res_valid) begin
        if (r_start < 0) begin
          r_start = cyc; r_id = res_id; r_max = res_max; r_to = res_timeout;
        end else if (res_id !== r_id || res_max !== r_max || res_timeout !== r_to) begin
          hold_err++;
        end
        if (grant != 4'b0000) grant_err++;
        if (cyc >= r_start + ready_delay) begin res_ready = 1'b1; a_cyc = cyc; end
        else res_ready = 1'b0;
      end
      s_bus = 8'($urandom); t_bus = 8'($urandom);
      if (grant != 4'b0000) sq.push_back({s_bus[2*li +: 2], t_bus[2*li +: 2]});
      eng_finish = 1'b0; eng_max = 12'($urandom);
      if (grant != 4'b0000 && g_len - 1 == spur_at) eng_finish = 1'b1;
      if (w_start >= 0 && r_start < 0 && fin_delay >= 0 && cyc == w_start + fin_delay) begin
        eng_finish = 1'b1; eng_max = mx;
      end
    end
    eng_finish = 1'b0;
    res_ready  = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; req = '0; res_ready = 1'b0; eng_finish = 1'b0; eng_max = '0;
    s_bus = 8'hFF; t_bus = 8'hFF;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({grant, rd_en, eng_valid, eng_s, eng_t, res_valid, res_id, res_max, res_timeout} !== 28'd0) begin
      n_fail++; $display("[TB] FAIL reset_outputs grant=%b rd_en=%b eng_valid=%b res_valid=%b res_max=%0d expected all 0",
                         grant, rd_en, eng_valid, res_valid, res_max);
    end
    n_checks++;
    if ({eng_rst, busy} !== 2'b11) begin
      n_fail++; $display("[TB] FAIL reset_rst_busy eng_rst=%b busy=%b expected 1 1", eng_rst, busy);
    end
    reset = 1'b0;
    exp_ptr = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 20);
    n_checks++;
    if (n != CLEAR_CYCLES || eng_rst !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_clear_len cycles=%0d eng_rst=%b expected %0d and 0", n, eng_rst, CLEAR_CYCLES);
    end
  endtask

  task automatic test_single_job();
    int fd;
    do_reset();
    fd = $urandom_range(0, 30);
    run_job(4'b0001, 1'b0, fd, 12'd40, -1, 0);
    n_checks++;
    if (job_done != 1) begin n_fail++; $display("[TB] FAIL single_done got=%0d expected=1", job_done); end
    n_checks++;
    if (g_val !== 4'b0001 || g_start != 1 || g_len != INPUT_LENGTH) begin
      n_fail++; $display("[TB] FAIL single_grant grant=%b start=%0d len=%0d expected 0001 1 %0d", g_val, g_start, g_len, INPUT_LENGTH);
    end
    n_checks++;
    if (v_first != 2 || v_len != INPUT_LENGTH || v_last != INPUT_LENGTH + 1) begin
      n_fail++; $display("[TB] FAIL single_valid first=%0d len=%0d last=%0d expected 2 %0d %0d", v_first, v_len, v_last, INPUT_LENGTH, INPUT_LENGTH + 1);
    end
    n_checks++;
    if (data_err != 0 || rd_err != 0) begin
      n_fail++; $display("[TB] FAIL single_data data_err=%0d rd_err=%0d expected 0 0", data_err, rd_err);
    end
    n_checks++;
    if (w_start != INPUT_LENGTH + 1 || r_start != w_start + fd + 1) begin
      n_fail++; $display("[TB] FAIL single_latency wait=%0d res=%0d expected %0d %0d", w_start, r_start, INPUT_LENGTH + 1, INPUT_LENGTH + fd + 2);
    end
    n_checks++;
    if (r_id !== 2'd0 || r_max !== 12'd40 || r_to !== 1'b0) begin
      n_fail++; $display("[TB] FAIL single_result id=%0d max=%0d to=%b expected 0 40 0", r_id, r_max, r_to);
    end
    n_checks++;
    if (rst_len != CLEAR_CYCLES || extra_res != 0 || idle_seen != 1) begin
      n_fail++; $display("[TB] FAIL single_clear rst_len=%0d extra_res=%0d idle=%0d expected %0d 0 1", rst_len, extra_res, idle_seen, CLEAR_CYCLES);
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [11:0] mx;
    logic [3:0] rq;
    int fd;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      mx = 12'($urandom_range(1, 4095));
      fd = $urandom_range(0, 20);
      run_job(4'b1111, 1'b1, fd, mx, -1, 0);
      n_checks++;
      if (job_done != 1 || g_val !== 4'(1 << order[j]) || r_id !== 2'(order[j]) || r_max !== mx) begin
        n_fail++; $display("[TB] FAIL rr_order job=%0d grant=%b id=%0d max=%0d expected %b %0d %0d",
                           j, g_val, r_id, r_max, 4'(1 << order[j]), order[j], mx);
      end
      if (j > 0) begin
        n_checks++;
        if (g_start != 1) begin
          n_fail++; $display("[TB] FAIL rr_earliest_grant job=%0d start=%0d expected 1", j, g_start);
        end
      end
    end
    req = '0;
    for (int j = 0; j < 6; j++) begin
      rq = 4'($urandom_range(1, 15));
      mx = 12'($urandom_range(0, 4095));
      fd = $urandom_range(0, 20);
      run_job(rq, 1'b0, fd, mx, -1, 0);
      n_checks++;
      if (job_done != 1 || g_val !== 4'(1 << exp_id) || r_id !== exp_id || r_max !== mx || r_to !== 1'b0) begin
        n_fail++; $display("[TB] FAIL rr_random req=%b grant=%b id=%0d max=%0d expected %b %0d %0d",
                           rq, g_val, r_id, r_max, 4'(1 << exp_id), exp_id, mx);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [11:0] mx;
    mx = 12'($urandom_range(1, 4095));
    run_job(4'b0100, 1'b0, $urandom_range(0, 20), mx, -1, 20);
    n_checks++;
    if (job_done != 1 || hold_err != 0 || grant_err != 0) begin
      n_fail++; $display("[TB] FAIL bp_hold done=%0d hold_err=%0d grant_err=%0d expected 1 0 0", job_done, hold_err, grant_err);
    end
    n_checks++;
    if (a_cyc - r_start != 20 || r_id !== exp_id || r_max !== mx) begin
      n_fail++; $display("[TB] FAIL bp_result wait=%0d id=%0d max=%0d expected 20 %0d %0d", a_cyc - r_start, r_id, r_max, exp_id, mx);
    end
    n_checks++;
    if (rst_len != CLEAR_CYCLES || extra_res != 0) begin
      n_fail++; $display("[TB] FAIL bp_accept rst_len=%0d extra_res=%0d expected %0d 0", rst_len, extra_res, CLEAR_CYCLES);
    end
  endtask

  task automatic test_timeout();
    logic [11:0] mx;
    run_job(4'($urandom_range(1, 15)), 1'b0, -1, 12'd0, -1, 0);
    n_checks++;
    if (job_done != 1 || r_start - w_start != TIMEOUT || r_to !== 1'b1 || r_max !== 12'd0 || r_id !== exp_id) begin
      n_fail++; $display("[TB] FAIL timeout delay=%0d to=%b max=%0d id=%0d expected %0d 1 0 %0d",
                         r_start - w_start, r_to, r_max, r_id, TIMEOUT, exp_id);
    end
    // finish arriving on the very last WAIT cycle beats the timeout
    mx = 12'($urandom_range(1, 4095));
    run_job(4'($urandom_range(1, 15)), 1'b0, TIMEOUT - 1, mx, -1, 0);
    n_checks++;
    if (job_done != 1 || r_start - w_start != TIMEOUT || r_to !== 1'b0 || r_max !== mx || r_id !== exp_id) begin
      n_fail++; $display("[TB] FAIL finish_at_limit delay=%0d to=%b max=%0d id=%0d expected %0d 0 %0d %0d",
                         r_start - w_start, r_to, r_max, r_id, TIMEOUT, mx, exp_id);
    end
  endtask

  task automatic test_spurious_finish();
    logic [11:0] mx;
    int fd;
    mx = 12'($urandom_range(1, 4095));
    fd = $urandom_range(0, 20);
    run_job(4'($urandom_range(1, 15)), 1'b0, fd, mx, 100, 0);
    n_checks++;
    if (job_done != 1 || g_len != INPUT_LENGTH || v_len != INPUT_LENGTH || data_err != 0) begin
      n_fail++; $display("[TB] FAIL spurious_load grant_len=%0d valid_len=%0d data_err=%0d expected %0d %0d 0",
                         g_len, v_len, data_err, INPUT_LENGTH, INPUT_LENGTH);
    end
    n_checks++;
    if (r_start != w_start + fd + 1 || r_max !== mx || r_to !== 1'b0) begin
      n_fail++; $display("[TB] FAIL spurious_result res=%0d max=%0d to=%b expected %0d %0d 0", r_start, r_max, r_to, w_start + fd + 1, mx);
    end
  endtask

  task automatic test_reset_mid_load();
    int n, g, bad;
    logic [11:0] mx;
    do_reset();
    req = 4'b0001; g = 0; n = 0;
    while (g < 51 && n < 100) begin
      @(negedge clk); n++;
      s_bus = 8'($urandom); t_bus = 8'($urandom);
      if (grant != 4'b0000) begin g++; req = 4'b0000; end
    end
    n_checks++;
    if (g != 51) begin n_fail++; $display("[TB] FAIL midload_reach symbols=%0d expected 51", g); end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({grant, rd_en, eng_valid, eng_s, eng_t, res_valid, res_id, res_max, res_timeout} !== 28'd0 || {eng_rst, busy} !== 2'b11) begin
      n_fail++; $display("[TB] FAIL midload_reset grant=%b rd_en=%b eng_valid=%b eng_s=%b eng_rst=%b busy=%b expected 0 0 0 0 1 1",
                         grant, rd_en, eng_valid, eng_s, eng_rst, busy);
    end
    bad = 0;
    repeat (2) begin @(negedge clk); if (res_valid) bad++; end
    reset = 1'b0;
    exp_ptr = 0;
    n = 0;
    do begin @(negedge clk); n++; if (res_valid) bad++; end while (busy && n < 20);
    n_checks++;
    if (bad != 0 || n != CLEAR_CYCLES) begin
      n_fail++; $display("[TB] FAIL midload_abort res_valid_seen=%0d clear=%0d expected 0 %0d", bad, n, CLEAR_CYCLES);
    end
    mx = 12'($urandom_range(1, 4095));
    run_job(4'b0011, 1'b0, $urandom_range(0, 10), mx, -1, 0);
    n_checks++;
    if (job_done != 1 || g_val !== 4'b0001 || r_id !== 2'd0 || r_max !== mx) begin
      n_fail++; $display("[TB] FAIL midload_ptr grant=%b id=%0d max=%0d expected 0001 0 %0d", g_val, r_id, r_max, mx);
    end
    mx = 12'($urandom_range(1, 4095));
    run_job(4'b0010, 1'b0, $urandom_range(0, 10), mx, -1, 0);
    n_checks++;
    if (job_done != 1 || g_val !== 4'b0010 || r_id !== 2'd1 || r_max !== mx || g_start != 1) begin
      n_fail++; $display("[TB] FAIL midload_next grant=%b id=%0d max=%0d start=%0d expected 0010 1 %0d 1", g_val, r_id, r_max, g_start, mx);
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_back_pressure();
    test_timeout();
    test_spurious_finish();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Overall time limit so a stuck DUT cannot hang the run
  initial begin
    #1000000;
    $display("[TB] FAIL global_time_limit elapsed=%0t limit=1000000", $time);
    $fatal(1, "[TB] time limit reached");
  end

endmodule
